// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one fsm_master I2C engine between NUM_REQ clients.
// Latches the winner's operands, launches the engine and returns a done or err pulse.
module i2c_master_arbiter #(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned ADDR_LEN = 7,
   parameter int unsigned DATA_LEN = 8,
   parameter int unsigned TIMEOUT  = 1023
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*ADDR_LEN-1:0]  req_addr,
   input  logic [NUM_REQ-1:0]           req_rw,
   input  logic [NUM_REQ*DATA_LEN-1:0]  req_data1,
   input  logic [NUM_REQ*DATA_LEN-1:0]  req_data2,
   output logic [NUM_REQ-1:0]           gnt,
   output logic [NUM_REQ-1:0]           done,
   output logic [NUM_REQ-1:0]           err,
   output logic                         m_start,
   output logic [ADDR_LEN-1:0]          m_add_reg,
   output logic                         m_R_W,
   output logic [DATA_LEN-1:0]          m_data_1,
   output logic [DATA_LEN-1:0]          m_data_2,
   input  logic                         m_free
);

   localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned SumW = PtrW + 1;
   localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      StIdle,
      StLaunch,
      StWaitBusy,
      StWaitFree
   } state_e;

   state_e              state_q, state_d;
   logic [PtrW-1:0]     ptr_q, ptr_d;
   logic [PtrW-1:0]     win_q, win_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [NUM_REQ-1:0]  done_q, done_d;
   logic [NUM_REQ-1:0]  err_q, err_d;
   logic [ADDR_LEN-1:0] addr_q, addr_d;
   logic                rw_q, rw_d;
   logic [DATA_LEN-1:0] data1_q, data1_d;
   logic [DATA_LEN-1:0] data2_q, data2_d;

   logic                pick_found;
   logic [PtrW-1:0]     pick_idx;
   logic [SumW-1:0]     pick_sum;
   logic [PtrW-1:0]     ptr_after_win;

   // Scan requests starting at ptr_q, wrapping modulo NUM_REQ; first hit wins.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      pick_sum   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         pick_sum = {1'b0, ptr_q} + SumW'(i);
         if (pick_sum >= SumW'(NUM_REQ)) begin
            pick_sum = pick_sum - SumW'(NUM_REQ);
         end
         if (!pick_found && req[pick_sum[PtrW-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = pick_sum[PtrW-1:0];
         end
      end
   end

   always_comb begin
      ptr_after_win = (win_q == PtrW'(NUM_REQ - 1)) ? '0 : win_q + PtrW'(1);
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      cnt_d   = cnt_q;
      done_d  = '0;
      err_d   = '0;
      addr_d  = addr_q;
      rw_d    = rw_q;
      data1_d = data1_q;
      data2_d = data2_q;

      unique case (state_q)
         StIdle: begin
            if (pick_found && m_free) begin
               win_d   = pick_idx;
               addr_d  = req_addr[pick_idx*ADDR_LEN +: ADDR_LEN];
               rw_d    = req_rw[pick_idx];
               data1_d = req_data1[pick_idx*DATA_LEN +: DATA_LEN];
               data2_d = req_data2[pick_idx*DATA_LEN +: DATA_LEN];
               state_d = StLaunch;
            end
         end
         StLaunch: begin
            cnt_d   = '0;
            state_d = StWaitBusy;
         end
         StWaitBusy: begin
            if (!m_free) begin
               state_d = StWaitFree;
            end else if (cnt_q == CntW'(TIMEOUT)) begin
               // Engine never acknowledged the start: give the slot up.
               err_d   = NUM_REQ'(1) << win_q;
               ptr_d   = ptr_after_win;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StWaitFree: begin
            if (m_free) begin
               done_d  = NUM_REQ'(1) << win_q;
               ptr_d   = ptr_after_win;
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         win_q   <= '0;
         cnt_q   <= '0;
         done_q  <= '0;
         err_q   <= '0;
         addr_q  <= '0;
         rw_q    <= 1'b0;
         data1_q <= '0;
         data2_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         rw_q    <= rw_d;
         data1_q <= data1_d;
         data2_q <= data2_d;
      end
   end

   // Grant is derived from the held winner so it is one-hot by construction.
   always_comb begin
      gnt       = (state_q != StIdle) ? (NUM_REQ'(1) << win_q) : '0;
      m_start   = (state_q == StLaunch);
      done      = done_q;
      err       = err_q;
      m_add_reg = addr_q;
      m_R_W     = rw_q;
      m_data_1  = data1_q;
      m_data_2  = data2_q;
   end

   a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
   a_done_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(done));
   a_err_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(err));
   a_no_overlap : assert property (@(posedge clk) disable iff (!rst_n)
                                   !((|done || |err) && |gnt));

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Randomized bench for i2c_master_arbiter with a transaction-level round-robin model
// and a behavioural fsm_master free-flag driver.
module tb_i2c_master_arbiter;

   localparam int NR = 4;
   localparam int AL = 7;
   localparam int DL = 8;
   localparam int TO = 40;

   logic            clk;
   logic            rst_n;
   logic [NR-1:0]   req;
   logic [NR*AL-1:0] req_addr;
   logic [NR-1:0]   req_rw;
   logic [NR*DL-1:0] req_data1;
   logic [NR*DL-1:0] req_data2;
   logic [NR-1:0]   gnt;
   logic [NR-1:0]   done;
   logic [NR-1:0]   err;
   logic            m_start;
   logic [AL-1:0]   m_add_reg;
   logic            m_R_W;
   logic [DL-1:0]   m_data_1;
   logic [DL-1:0]   m_data_2;
   logic            m_free;

   logic [AL-1:0]   addr_a  [NR];
   logic            rw_a    [NR];
   logic [DL-1:0]   d1_a    [NR];
   logic [DL-1:0]   d2_a    [NR];

   logic [NR-1:0]   req_v;
   int              ptr_m;
   int              n_cmp;
   int              n_err;

   i2c_master_arbiter #(
      .NUM_REQ (NR),
      .ADDR_LEN(AL),
      .DATA_LEN(DL),
      .TIMEOUT (TO)
   ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .req_addr (req_addr),
      .req_rw   (req_rw),
      .req_data1(req_data1),
      .req_data2(req_data2),
      .gnt      (gnt),
      .done     (done),
      .err      (err),
      .m_start  (m_start),
      .m_add_reg(m_add_reg),
      .m_R_W    (m_R_W),
      .m_data_1 (m_data_1),
      .m_data_2 (m_data_2),
      .m_free   (m_free)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      req_addr  = '0;
      req_rw    = '0;
      req_data1 = '0;
      req_data2 = '0;
      for (int i = 0; i < NR; i++) begin
         req_addr[i*AL +: AL]  = addr_a[i];
         req_rw[i]             = rw_a[i];
         req_data1[i*DL +: DL] = d1_a[i];
         req_data2[i*DL +: DL] = d2_a[i];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Round-robin rule: first requester at or after the pointer, wrapping.
   function automatic int pick(input logic [NR-1:0] r, input int p);
      for (int i = 0; i < NR; i++) begin
         if (r[(p + i) % NR]) return (p + i) % NR;
      end
      return -1;
   endfunction

   task automatic rand_ops();
      for (int i = 0; i < NR; i++) begin
         addr_a[i] = AL'($urandom);
         rw_a[i]   = 1'($urandom);
         d1_a[i]   = DL'($urandom);
         d2_a[i]   = DL'($urandom);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge showing done/err.
   task automatic do_txn(input bit to_mode, input bit drop, input int bdly, input int flen);
      int             w;
      int             cyc;
      int             bad;
      logic [AL-1:0]  e_addr;
      logic           e_rw;
      logic [DL-1:0]  e_d1;
      logic [DL-1:0]  e_d2;
      w      = pick(req_v, ptr_m);
      e_addr = addr_a[w];
      e_rw   = rw_a[w];
      e_d1   = d1_a[w];
      e_d2   = d2_a[w];
      req    = req_v;
      m_free = 1'b1;
      @(negedge clk);
      check("gnt", 32'(gnt), 32'd1 << w);
      check("m_start", 32'(m_start), 32'd1);
      check("done_clr", 32'(done), 32'd0);
      check("m_add_reg", 32'(m_add_reg), 32'(e_addr));
      check("m_R_W", 32'(m_R_W), 32'(e_rw));
      check("m_data_1", 32'(m_data_1), 32'(e_d1));
      check("m_data_2", 32'(m_data_2), 32'(e_d2));
      rand_ops();
      if (to_mode) begin
         cyc = 0;
         bad = 0;
         while (err == '0 && cyc < TO + 10) begin
            @(negedge clk);
            cyc++;
            if (done != '0) bad++;
         end
         check("err_latency", 32'(cyc), 32'(TO + 2));
         check("err", 32'(err), 32'd1 << w);
         check("gnt_clr_err", 32'(gnt), 32'd0);
         check("no_done_to", 32'(bad), 32'd0);
      end else begin
         for (int k = 0; k < bdly; k++) begin
            @(negedge clk);
            if (k == 0) begin
               check("m_start_1cyc", 32'(m_start), 32'd0);
               if (drop) begin
                  req_v[w] = 1'b0;
                  req      = req_v;
               end
            end
         end
         m_free = 1'b0;
         bad = 0;
         for (int k = 0; k < flen; k++) begin
            @(negedge clk);
            if (gnt !== NR'(1 << w) || done != '0 || err != '0 || m_start) bad++;
            if (m_add_reg !== e_addr || m_data_1 !== e_d1 || m_data_2 !== e_d2) bad++;
            if (k == flen / 2) rand_ops();
         end
         check("hold_wait_free", 32'(bad), 32'd0);
         m_free = 1'b1;
         @(negedge clk);
         check("done", 32'(done), 32'd1 << w);
         check("gnt_clr_done", 32'(gnt), 32'd0);
         check("err_clr", 32'(err), 32'd0);
         check("m_add_hold", 32'(m_add_reg), 32'(e_addr));
      end
      ptr_m    = (w + 1) % NR;
      req_v[w] = 1'b0;
      req      = req_v;
   endtask

   initial begin
      n_cmp  = 0;
      n_err  = 0;
      ptr_m  = 0;
      rst_n  = 1'b0;
      req_v  = '0;
      req    = '0;
      m_free = 1'b1;
      rand_ops();
      repeat (3) @(negedge clk);
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_start", 32'(m_start), 32'd0);
      check("rst_done_err", 32'({done, err}), 32'd0);
      check("rst_ops", 32'({m_add_reg, m_R_W, m_data_1}), 32'd0);
      rst_n = 1'b1;

      // Round-robin with everyone requesting: 0,1,2,3 then back to 0.
      for (int t = 0; t < 5; t++) begin
         req_v = 4'b1111;
         do_txn(1'b0, 1'b0, 2, 5);
      end

      // Single directed transaction from client 1.
      req_v     = 4'b0010;
      addr_a[1] = 7'h56;
      rw_a[1]   = 1'b1;
      d1_a[1]   = 8'hAB;
      d2_a[1]   = 8'hAB;
      do_txn(1'b0, 1'b0, 3, 40);

      // Engine never goes busy: timeout on client 2, then client 3 is next.
      req_v = 4'b1100;
      do_txn(1'b1, 1'b0, 1, 1);
      do_txn(1'b0, 1'b0, 1, 3);

      // Early drop of req[0] in WAIT_BUSY; next grant must skip client 0.
      req_v = 4'b0011;
      do_txn(1'b0, 1'b1, 2, 6);
      do_txn(1'b0, 1'b0, 1, 2);

      for (int t = 0; t < 60; t++) begin
         rand_ops();
         req_v = req_v | NR'($urandom_range(0, 15));
         if (req_v == '0) req_v[$urandom_range(0, NR - 1)] = 1'b1;
         do_txn($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(1, 4), $urandom_range(1, 20));
      end

      // Reset while in WAIT_FREE abandons the transaction.
      req_v = 4'b1001;
      req   = req_v;
      m_free = 1'b1;
      @(negedge clk);
      @(negedge clk);
      m_free = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_gnt", 32'(gnt), 32'd0);
      check("midrst_start", 32'(m_start), 32'd0);
      check("midrst_done_err", 32'({done, err}), 32'd0);
      check("midrst_ops", 32'(m_add_reg), 32'd0);
      @(negedge clk);
      rst_n  = 1'b1;
      ptr_m  = 0;
      req_v  = 4'b0100;
      rand_ops();
      do_txn(1'b0, 1'b0, 1, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
